seg_scan_mux: RTL and testbench

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

---
 rtl/seg_scan_mux_pkg.sv | 16 +
 rtl/seg_scan_mux_prescaler.sv | 37 +++
 rtl/seg_scan_mux.sv | 132 +++++++++++++
 tb/tb_seg_scan_mux.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_mux_pkg.sv
// Shared constants and state encoding for the multiplexed 7-segment scanner.
package seg_scan_mux_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam int DEF_DIGITS      = 4;
  localparam int DEF_REFRESH_DIV = 27000;
  localparam int DEF_GHOST_CYC   = 16;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GHOST = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg_scan_mux_prescaler.sv
// Digit-slot timebase: counts 0..REFRESH_DIV-1, flags the last cycle of a slot
// and the last cycle of the dark (ghost) window at the start of a slot.
module seg_scan_mux_prescaler #(
  parameter int REFRESH_DIV = 27000,
  parameter int GHOST_CYC   = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o,
  output logic ghost_end_o
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(REFRESH_DIV - 1);
  // With no ghost window the compare value is irrelevant; the enable masks it.
  localparam logic [CW-1:0] GHOST_CNT = CW'((GHOST_CYC > 0) ? GHOST_CYC - 1 : 0);
  localparam bit            GHOST_EN  = (GHOST_CYC > 0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o      = (cnt_q == LAST_CNT);
  assign ghost_end_o = GHOST_EN && (cnt_q == GHOST_CNT);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment driver: double-buffered frame, per-digit blanking,
// anti-ghosting dark window at the start of every digit slot.
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int DIGITS      = DEF_DIGITS,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int GHOST_CYC   = DEF_GHOST_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [7*DIGITS-1:0]   seg_in,
  input  logic [DIGITS-1:0]     blank,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     anode,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  logic              tick;
  logic              ghost_end;
  logic              wrap;

  scan_state_t       state_q;
  logic [IW-1:0]     index_q;

  logic [6:0]        seg_in_a    [DIGITS];
  logic [6:0]        sh_pat_q    [DIGITS];
  logic [6:0]        act_pat_q   [DIGITS];
  logic [DIGITS-1:0] sh_blank_q;
  logic [DIGITS-1:0] act_blank_q;
  logic              pending_q;

  logic              lit;
  logic [6:0]        seg_d;
  logic [DIGITS-1:0] anode_d;
  logic [6:0]        seg_q;
  logic [DIGITS-1:0] anode_q;
  logic              frame_done_q;

  seg_scan_mux_prescaler #(
    .REFRESH_DIV (REFRESH_DIV),
    .GHOST_CYC   (GHOST_CYC)
  ) u_prescaler (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_o      (tick),
    .ghost_end_o (ghost_end)
  );

  for (genvar k = 0; k < DIGITS; k++) begin : g_unpack
    assign seg_in_a[k] = seg_in[7*k +: 7];
  end

  assign wrap = tick && (index_q == LAST_IDX);

  // A load on the wrap cycle bypasses the shadow so it is shown this frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DIGITS; k++) begin
        sh_pat_q[k]  <= SEG_OFF;
        act_pat_q[k] <= SEG_OFF;
      end
      sh_blank_q  <= '1;
      act_blank_q <= '1;
      pending_q   <= 1'b0;
    end else begin
      if (load) begin
        sh_pat_q   <= seg_in_a;
        sh_blank_q <= blank;
      end
      if (wrap) begin
        if (load) begin
          act_pat_q   <= seg_in_a;
          act_blank_q <= blank;
        end else if (pending_q) begin
          act_pat_q   <= sh_pat_q;
          act_blank_q <= sh_blank_q;
        end
        pending_q <= 1'b0;
      end else if (load) begin
        pending_q <= 1'b1;
      end
    end
  end

  always_comb begin
    lit     = (state_q == ST_DRIVE) && !act_blank_q[index_q];
    seg_d   = lit ? act_pat_q[index_q] : SEG_OFF;
    anode_d = '1;
    if (lit) begin
      anode_d[index_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_OFF;
      index_q      <= '0;
      seg_q        <= SEG_OFF;
      anode_q      <= '1;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      anode_q      <= anode_d;
      frame_done_q <= wrap;
      if (tick) begin
        index_q <= wrap ? '0 : index_q + IW'(1);
      end
      case (state_q)
        ST_OFF: begin
          if (tick) state_q <= (GHOST_CYC == 0) ? ST_DRIVE : ST_GHOST;
        end
        ST_GHOST: begin
          if (ghost_end) state_q <= ST_DRIVE;
        end
        ST_DRIVE: begin
          if (tick) state_q <= (GHOST_CYC == 0) ? ST_DRIVE : ST_GHOST;
        end
        default: state_q <= ST_OFF;
      endcase
    end
  end

  assign seg_out    = seg_q;
  assign anode      = anode_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: stimulus queues the expected lit digit
// slots per frame, a negedge monitor pops them as the display lights up.
module tb_seg_scan_mux;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int GC = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          load  = 1'b0;
  logic [7*D-1:0] seg_in = '0;
  logic [D-1:0]  blank = '0;
  logic [6:0]    seg_out;
  logic [D-1:0]  anode;
  logic          frame_done;

  seg_scan_mux #(
    .DIGITS      (D),
    .REFRESH_DIV (RD),
    .GHOST_CYC   (GC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .seg_in     (seg_in),
    .blank      (blank),
    .seg_out    (seg_out),
    .anode      (anode),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } slot_t;

  slot_t sb[$];

  // Monitor: slot starts pop the scoreboard; dark cycles, slot length and
  // frame period are checked against fixed timing (6 lit cycles, 32-cycle frame).
  logic [3:0] prev_an = 4'hF;
  int         run_len = 0;
  int         cyc_rst = 0;
  int         last_fd = 0;
  slot_t      exp_s;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_an = 4'hF;
      run_len = 0;
      cyc_rst = 0;
      last_fd = 0;
    end else begin
      cyc_rst++;
      check("one_anode_low", 32'($countones(~anode) <= 1), 32'd1);
      if (frame_done) begin
        check("frame_period", cyc_rst - last_fd, 32);
        last_fd = cyc_rst;
      end
      if (prev_an != 4'hF && anode != prev_an) begin
        check("slot_len", run_len, 6);
        run_len = 0;
      end
      if (anode == 4'hF) begin
        check("dark_seg", seg_out, 7'h7F);
      end else begin
        if (anode != prev_an) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_slot: got anode %b seg %h expected dark at %0t",
                     anode, seg_out, $time);
          end else begin
            exp_s = sb.pop_front();
            check("slot_anode", anode, exp_s.an);
            check("slot_seg", seg_out, exp_s.seg);
          end
          run_len = 0;
        end
        run_len++;
      end
      prev_an = anode;
    end
  end

  logic [7*D-1:0] m_act, m_sh;
  logic [D-1:0]   m_ablk, m_sblk;
  logic           m_pend;

  localparam logic [27:0] PA  = {7'h12, 7'h24, 7'h79, 7'h40};
  localparam logic [27:0] PB0 = {7'h12, 7'h24, 7'h79, 7'h00};
  localparam logic [27:0] PB8 = {7'h12, 7'h24, 7'h79, 7'h08};
  localparam logic [27:0] PD  = {7'h30, 7'h30, 7'h30, 7'h30};
  localparam logic [27:0] PC  = {7'h66, 7'h4F, 7'h5B, 7'h06};
  localparam logic [27:0] PE  = {7'h01, 7'h01, 7'h01, 7'h01};

  task automatic push_frame();
    slot_t s;
    for (int k = 0; k < D; k++) begin
      if (!m_ablk[k]) begin
        s.an    = 4'hF;
        s.an[k] = 1'b0;
        s.seg   = m_act[7*k +: 7];
        sb.push_back(s);
      end
    end
  endtask

  // Returns at the negedge where frame_done is seen (one cycle after the wrap edge).
  task automatic frame_begin();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (frame_done) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_timeout: got no frame_done expected one within 40 cycles");
    end
    if (m_pend) begin
      m_act  = m_sh;
      m_ablk = m_sblk;
      m_pend = 1'b0;
    end
    push_frame();
  endtask

  task automatic do_load(input logic [27:0] p, input logic [3:0] b);
    seg_in = p;
    blank  = b;
    load   = 1'b1;
    m_sh   = p;
    m_sblk = b;
    m_pend = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic clear_model();
    m_act  = {D{7'h7F}};
    m_sh   = {D{7'h7F}};
    m_ablk = '1;
    m_sblk = '1;
    m_pend = 1'b0;
  endtask

  initial begin
    clear_model();
    #1 rst_n = 1'b0;
    #1;
    check("rst_anode", anode, 4'hF);
    check("rst_seg", seg_out, 7'h7F);
    check("rst_frame_done", frame_done, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Idle: dark display, frame_done every 32 cycles.
    repeat (100) @(negedge clk);
    frame_begin();

    // Basic pattern, shown from the next frame onward.
    repeat (3) @(negedge clk);
    do_load(PA, 4'b0000);
    frame_begin();
    frame_begin();

    // Digit 2 blanked.
    repeat (2) @(negedge clk);
    do_load(PA, 4'b0100);
    frame_begin();
    frame_begin();

    // Two loads inside one frame: current frame untouched, latest wins at wrap.
    repeat (4) @(negedge clk);
    do_load(PB0, 4'b0000);
    repeat (6) @(negedge clk);
    do_load(PB8, 4'b0000);
    frame_begin();
    frame_begin();

    // Pending load earlier in the frame, then a load exactly on the wrap cycle.
    do_load(PD, 4'b0000);
    repeat (30) @(negedge clk);
    seg_in = PC;
    blank  = 4'b0000;
    load   = 1'b1;
    m_act  = PC;
    m_ablk = 4'b0000;
    m_sh   = PC;
    m_sblk = 4'b0000;
    m_pend = 1'b0;
    frame_begin();
    frame_begin();

    // Reset in the middle of digit 0's lit window with a load pending.
    do_load(PE, 4'b0000);
    repeat (3) @(negedge clk);
    check("pre_rst_lit_anode", anode, 4'b1110);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_anode", anode, 4'hF);
    check("mid_rst_seg", seg_out, 7'h7F);
    check("mid_rst_frame_done", frame_done, 1'b0);
    sb.delete();
    clear_model();
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (80) @(negedge clk);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
